nmcu_burst_mem: RTL
===================

Name: nmcu_burst_mem

Overview:
Parametrised simulated main memory for the NMCU testbench and chiplet integration. It is the next generation of the fixed-latency word memory. It adds valid/ready backpressure on both channels, multi-beat read and write bursts driven by the request length field, and a configurable latency and depth. It sits behind the cache/PE memory port and serves the flattened request/response structures.

Parameters:
- DATA_WIDTH, 32, data word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 32, byte-address width.
- LEN_WIDTH, 8, burst-length field width.
- DEPTH_WORDS, 16384, storage depth in words.
- LATENCY, 5, cycles from request acceptance to first response beat; legal range 1 to 255.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request beat valid
- req_ready  out  1  request beat accepted when high with req_valid
- req_write_en  in  1  1 = write, 0 = read; sampled on first beat
- req_addr  in  ADDR_WIDTH  byte start address; sampled on first beat
- req_wdata  in  DATA_WIDTH  write data, one word per beat
- req_len  in  LEN_WIDTH  burst length in words; 0 is treated as 1; sampled on first beat
- resp_valid  out  1  response beat valid
- resp_ready  in  1  response beat consumed when high with resp_valid
- resp_addr  out  ADDR_WIDTH  byte address of this beat
- resp_rdata  out  DATA_WIDTH  read data; 0 for write acknowledges
- resp_hit  out  1  constant 1 whenever resp_valid is high
- resp_last  out  1  final beat of the burst

Behaviour:
- Clock and reset: single clock clk; rst_n is asynchronous and active-low.
- Reset values: req_ready=1, resp_valid=0, resp_last=0, resp_addr=0, resp_rdata=0, state=IDLE, all counters 0.
- Reset does not clear storage contents.
- Addressing: word index = (byte addr >> log2(DATA_WIDTH/8)) modulo DEPTH_WORDS. Low byte-offset bits are ignored.
- Beat k of a burst uses start word index + k, wrapping from DEPTH_WORDS-1 to 0.
- resp_addr reports the byte address of the beat, i.e. start + k*DATA_WIDTH/8, truncated to ADDR_WIDTH.
- Only one burst is in flight at a time.
- IDLE: req_ready=1.
  - On read accept: latch addr/len, go to RD_WAIT.
  - On write accept: write beat 0 into storage in the accept cycle. If len<=1 go to WR_WAIT; otherwise go to WR_DATA.
- WR_DATA: req_ready=1. Each accepted beat writes the next word. req_addr, req_len and req_write_en are ignored in this state. After beat len-1 go to WR_WAIT.
- RD_WAIT / WR_WAIT: req_ready=0. The latency counter runs.
  - The first response is presented LATENCY cycles after the accepting edge: accept at edge T gives resp_valid high after edge T+LATENCY.
  - For a write, LATENCY counts from the final data beat.
- RD_BURST: resp_valid=1 with current-beat data.
  - On resp_ready, advance to the next beat; back-to-back beats stream at 1 per cycle.
  - When resp_ready is low, all response outputs are held stable.
  - resp_last=1 on beat len-1. Its handshake returns the block to IDLE, and req_ready rises the next cycle.
- Write acknowledge: a single beat with resp_valid=1, resp_addr=start address, resp_rdata=0, resp_last=1. The handshake returns the block to IDLE.
- Read data is sampled from storage when the beat is presented, so read-after-write to the same address returns the new data.
- Asynchronous reset mid-burst aborts it: resp_valid drops immediately and req_ready returns to 1.
- Length: len=0 behaves exactly as len=1. The maximum burst is 2^LEN_WIDTH-1 words.

Optional Feature:
Macro NMCU_MEM_BOUNDS_CHECK_EN.
- Defined:
  - Adds output port resp_err (1 bit, reset 0).
  - Any beat whose unwrapped word index is >= DEPTH_WORDS is out of range.
  - Out-of-range reads return rdata=0 with resp_err=1 for that beat.
  - Out-of-range write beats are dropped, and the write acknowledge carries resp_err=1 if any beat was dropped.
  - No index wrap occurs.
- Undefined: no resp_err port; indices wrap modulo DEPTH_WORDS as described above.

Test Plan:
1. Reset: hold rst_n=0 for 3 cycles -> req_ready=1, resp_valid=0, resp_last=0; release, idle 10 cycles -> no response.
2. Single write then read: write addr=0x100, wdata=0xDEADBEEF, len=1 -> one ack after 5 cycles with resp_rdata=0, resp_last=1. Then read 0x100, len=1 -> resp_rdata=0xDEADBEEF, resp_addr=0x100, resp_last=1, exactly 5 cycles after accept.
3. Write burst then read burst: write len=4 at 0x200 with data 1,2,3,4 -> one ack. Read len=4 -> 4 back-to-back beats, addr 0x200/0x204/0x208/0x20C, data 1..4, resp_last only on the 4th; req_ready=0 throughout.
4. Backpressure: read len=3 with resp_ready toggling 1,0,0,1,1 -> each beat held stable while stalled; exactly 3 handshakes, data in order, no duplicates.
5. Wrap/bounds: read len=2 from word index 16383 (byte 0xFFFC) -> without the macro, beats are word 16383 then word 0; with NMCU_MEM_BOUNDS_CHECK_EN, beat 2 has rdata=0 and resp_err=1. Also read with len=0 -> identical to len=1.
6. Reset mid-burst: assert rst_n=0 during beat 2 of a len=8 read -> resp_valid=0 asynchronously. After release, req_ready=1; a new read of 0x200 returns the previously written data.

Source files
------------

// File: rtl/nmcu_burst_mem.sv
// nmcu_burst_mem: latency-programmable burst memory with valid/ready request and response channels.
// Define NMCU_MEM_BOUNDS_CHECK_EN to add resp_err and replace index wrap with out-of-range detection.
module nmcu_burst_mem #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int LEN_WIDTH   = 8,
  parameter int DEPTH_WORDS = 16384,
  parameter int LATENCY     = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write_en,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [LEN_WIDTH-1:0]  req_len,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [ADDR_WIDTH-1:0] resp_addr,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_hit,
  output logic                  resp_last
`ifdef NMCU_MEM_BOUNDS_CHECK_EN
  ,
  output logic                  resp_err
`endif
);
  localparam int OFFS = $clog2(DATA_WIDTH / 8);
  localparam int IDXW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int UW   = ADDR_WIDTH + 1;

  typedef enum logic [2:0] {IDLE, WR_DATA, RD_WAIT, WR_WAIT, RD_BURST, WR_ACK} state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH_WORDS];
  logic [ADDR_WIDTH-1:0] r_start;
  logic [LEN_WIDTH-1:0]  r_len;
  logic [LEN_WIDTH-1:0]  r_beat;
  logic [7:0]            r_lat;
  logic                  r_req_ready;
  logic                  r_resp_valid;
  logic                  r_resp_last;
  logic [ADDR_WIDTH-1:0] r_resp_addr;
  logic [DATA_WIDTH-1:0] r_resp_rdata;

  logic                  w_idle;
  logic                  w_acc;
  logic                  w_hs;
  logic                  w_we;
  logic                  w_rpres;
  logic                  w_roob;
  logic                  w_woob;
  logic [LEN_WIDTH-1:0]  w_nbeat;
  logic [LEN_WIDTH-1:0]  w_len0;
  logic [UW-1:0]         w_rword;
  logic [UW-1:0]         w_wword;

  function automatic logic [IDXW-1:0] f_idx(input logic [UW-1:0] u);
    return IDXW'(u % UW'(DEPTH_WORDS));
  endfunction

  assign w_idle  = r_state == IDLE;
  assign w_acc   = req_valid && r_req_ready;
  assign w_hs    = r_resp_valid && resp_ready;
  assign w_we    = w_acc && (w_idle ? req_write_en : 1'b1);
  assign w_len0  = (req_len == '0) ? LEN_WIDTH'(1) : req_len;
  assign w_nbeat = (r_state == RD_BURST) ? r_beat + LEN_WIDTH'(1) : '0;
  assign w_rword = UW'(r_start >> OFFS) + UW'(w_nbeat);
  assign w_wword = w_idle ? UW'(req_addr >> OFFS) : UW'(r_start >> OFFS) + UW'(r_beat);
  // a read beat is loaded when the wait expires or when a non-final beat is consumed
  assign w_rpres = (r_state == RD_WAIT && r_lat == '0) || (r_state == RD_BURST && w_hs && !r_resp_last);

`ifdef NMCU_MEM_BOUNDS_CHECK_EN
  logic r_werr;
  logic r_resp_err;
  assign w_roob   = w_rword >= UW'(DEPTH_WORDS);
  assign w_woob   = w_wword >= UW'(DEPTH_WORDS);
  assign resp_err = r_resp_err;
`else
  assign w_roob = 1'b0;
  assign w_woob = 1'b0;
`endif

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_addr  = r_resp_addr;
  assign resp_rdata = r_resp_rdata;
  assign resp_last  = r_resp_last;
  assign resp_hit   = r_resp_valid;

  // storage survives reset
  always_ff @(posedge clk) begin
    if (w_we && !w_woob) r_mem[f_idx(w_wword)] <= req_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_start      <= '0;
      r_len        <= '0;
      r_beat       <= '0;
      r_lat        <= '0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_last  <= 1'b0;
      r_resp_addr  <= '0;
      r_resp_rdata <= '0;
`ifdef NMCU_MEM_BOUNDS_CHECK_EN
      r_werr       <= 1'b0;
      r_resp_err   <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: if (w_acc) begin
          r_start     <= req_addr;
          r_len       <= w_len0;
          r_beat      <= LEN_WIDTH'(req_write_en);
          r_lat       <= 8'(LATENCY - 1);
          r_req_ready <= req_write_en && w_len0 != LEN_WIDTH'(1);
          r_state     <= !req_write_en ? RD_WAIT : (w_len0 == LEN_WIDTH'(1)) ? WR_WAIT : WR_DATA;
`ifdef NMCU_MEM_BOUNDS_CHECK_EN
          r_werr      <= w_woob;
`endif
        end
        WR_DATA: if (w_acc) begin
          r_beat <= r_beat + LEN_WIDTH'(1);
`ifdef NMCU_MEM_BOUNDS_CHECK_EN
          r_werr <= r_werr | w_woob;
`endif
          if (r_beat == r_len - LEN_WIDTH'(1)) begin
            r_state     <= WR_WAIT;
            r_req_ready <= 1'b0;
          end
        end
        RD_WAIT: if (r_lat != '0) r_lat <= r_lat - 8'd1;
        else begin
          r_state      <= RD_BURST;
          r_resp_valid <= 1'b1;
        end
        WR_WAIT: if (r_lat != '0) r_lat <= r_lat - 8'd1;
        else begin
          r_state      <= WR_ACK;
          r_resp_valid <= 1'b1;
          r_resp_addr  <= r_start;
          r_resp_rdata <= '0;
          r_resp_last  <= 1'b1;
`ifdef NMCU_MEM_BOUNDS_CHECK_EN
          r_resp_err   <= r_werr;
`endif
        end
        default: if (w_hs) begin
          if (r_resp_last) begin
            r_state      <= IDLE;
            r_resp_valid <= 1'b0;
            r_resp_last  <= 1'b0;
            r_req_ready  <= 1'b1;
`ifdef NMCU_MEM_BOUNDS_CHECK_EN
            r_resp_err   <= 1'b0;
`endif
          end else r_beat <= w_nbeat;
        end
      endcase
      if (w_rpres) begin
        r_resp_addr  <= r_start + (ADDR_WIDTH'(w_nbeat) << OFFS);
        r_resp_rdata <= w_roob ? '0 : r_mem[f_idx(w_rword)];
        r_resp_last  <= w_nbeat == r_len - LEN_WIDTH'(1);
`ifdef NMCU_MEM_BOUNDS_CHECK_EN
        r_resp_err   <= w_roob;
`endif
      end
    end
  end
endmodule
